perceptron_trainer: RTL

- Parametrised sequential trainer for a single-layer perceptron with bias.
- Stores N_SMP training samples and trains online, sample by sample, in index order. Stops when an epoch completes with zero errors or when MAX_EPOCH epochs have run.
- Uses a single time-multiplexed multiplier and adder in signed fixed-point. This replaces the fully unrolled combinational epoch and makes width, input count and sample count parametric.

---
 rtl/perceptron_trainer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/perceptron_trainer.sv
// Sequential single-layer perceptron trainer: one shared multiplier/adder, online updates in sample order.
// Build option: define PERCEPTRON_SAT_EN to saturate weight updates instead of wrapping modulo 2^W.
module perceptron_trainer #(
  parameter int N_IN      = 2,
  parameter int N_SMP     = 4,
  parameter int W         = 16,
  parameter int FRAC      = 8,
  parameter int MAX_EPOCH = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ld_valid,
  input  logic [$clog2(N_SMP)-1:0]       ld_idx,
  input  logic [N_IN*W-1:0]              ld_x,
  input  logic                           ld_d,
  input  logic [(N_IN+1)*W-1:0]          w_init,
  input  logic [W-1:0]                   u,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output logic [$clog2(MAX_EPOCH+1)-1:0] epoch_cnt,
  output logic [$clog2(N_SMP+1)-1:0]     err_cnt,
  output logic [(N_IN+1)*W-1:0]          w_out,
  output logic [N_SMP-1:0]               y_out
);

  localparam int IW = $clog2(N_SMP);
  localparam int KW = $clog2(N_IN + 1);
  localparam int EW = $clog2(MAX_EPOCH + 1);
  localparam int CW = $clog2(N_SMP + 1);
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + KW;

  localparam logic [KW-1:0]       K_LAST   = KW'(N_IN);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_SMP - 1);
  localparam logic [EW-1:0]       EP_LIMIT = EW'(MAX_EPOCH);
  localparam logic signed [W-1:0] ONE      = W'(1 << FRAC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_MAC,
    S_DECIDE,
    S_UPDATE,
    S_EPOCH_END,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N_IN*W-1:0]   smp_x_q [N_SMP];
  logic [N_SMP-1:0]    smp_d_q;

  logic signed [W-1:0] w_q [N_IN+1];
  logic signed [W-1:0] w_d [N_IN+1];
  logic signed [W-1:0] u_q, u_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [KW-1:0]       k_q, k_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       err_q, err_d;
  logic [CW-1:0]       err_cnt_q, err_cnt_d;
  logic [EW-1:0]       epoch_q, epoch_d;
  logic                conv_q, conv_d;
  logic [N_SMP-1:0]    y_q, y_d;

  logic                ld_we;
  logic [N_IN*W-1:0]   cur_x;
  logic                cur_d;
  logic signed [W-1:0] x_k;
  logic signed [W-1:0] mul_a;
  logic signed [PW-1:0] prod;
  logic signed [W-1:0] delta;
  logic                y_now;
  logic                adv;

  // Two's-complement add/subtract of one weight step; saturating build clamps at the W-bit limits.
  function automatic logic signed [W-1:0] upd_weight(input logic signed [W-1:0] w_in,
                                                     input logic signed [W-1:0] dlt,
                                                     input logic            add);
    logic signed [W:0] sum;
    sum = add ? ((W+1)'(w_in) + (W+1)'(dlt)) : ((W+1)'(w_in) - (W+1)'(dlt));
    upd_weight = sum[W-1:0];
`ifdef PERCEPTRON_SAT_EN
    if (sum[W] != sum[W-1])
      upd_weight = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  endfunction

  // Sample store is deliberately left out of reset so samples survive a mid-run reset.
  assign ld_we = ld_valid && !busy && (int'(ld_idx) < N_SMP);

  always_ff @(posedge clk) begin
    if (ld_we) begin
      smp_x_q[ld_idx] <= ld_x;
      smp_d_q[ld_idx] <= ld_d;
    end
  end

  assign cur_x = smp_x_q[idx_q];
  assign cur_d = smp_d_q[idx_q];

  always_comb begin
    x_k = ONE;
    for (int i = 0; i < N_IN; i++) begin
      if (k_q == KW'(i + 1)) x_k = cur_x[i*W +: W];
    end
  end

  // The single multiplier serves w[k]*x'[k] during MAC and u*x'[k] during UPDATE.
  assign mul_a = (state_q == S_UPDATE) ? u_q : w_q[k_q];
  assign prod  = PW'(mul_a) * PW'(x_k);
  assign delta = W'(prod >>> FRAC);
  assign y_now = ~acc_q[AW-1];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    idx_d     = idx_q;
    acc_d     = '0;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    epoch_d   = epoch_q;
    conv_d    = conv_q;
    u_d       = u_q;
    y_d       = y_q;
    adv       = 1'b0;
    for (int i = 0; i <= N_IN; i++) w_d[i] = w_q[i];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        for (int i = 0; i <= N_IN; i++) w_d[i] = w_init[i*W +: W];
        u_d     = u;
        epoch_d = '0;
        conv_d  = 1'b0;
        err_d   = '0;
        idx_d   = '0;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + AW'(prod);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DECIDE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DECIDE: begin
        y_d[idx_q] = y_now;
        if (y_now != cur_d) begin
          err_d   = err_q + CW'(1);
          k_d     = '0;
          state_d = S_UPDATE;
        end else begin
          adv = 1'b1;
        end
      end
      S_UPDATE: begin
        // A misclassified d=1 sample pushes weights up; a misclassified d=0 sample pushes them down.
        w_d[k_q] = upd_weight(w_q[k_q], delta, cur_d);
        if (k_q == K_LAST) adv = 1'b1;
        else               k_d = k_q + KW'(1);
      end
      S_EPOCH_END: begin
        epoch_d   = epoch_q + EW'(1);
        err_cnt_d = err_q;
        err_d     = '0;
        idx_d     = '0;
        k_d       = '0;
        if (err_q == '0) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (epoch_d == EP_LIMIT) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Advancing to the next sample costs no cycle of its own.
    if (adv) begin
      k_d = '0;
      if (idx_q == IDX_LAST) begin
        state_d = S_EPOCH_END;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = S_MAC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      err_q     <= '0;
      err_cnt_q <= '0;
      epoch_q   <= '0;
      conv_q    <= 1'b0;
      u_q       <= '0;
      y_q       <= '0;
      for (int i = 0; i <= N_IN; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      epoch_q   <= epoch_d;
      conv_q    <= conv_d;
      u_q       <= u_d;
      y_q       <= y_d;
      for (int i = 0; i <= N_IN; i++) w_q[i] <= w_d[i];
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign converged = conv_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt   = err_cnt_q;
  assign y_out     = y_q;

  for (genvar g = 0; g <= N_IN; g++) begin : g_wout
    assign w_out[g*W +: W] = w_q[g];
  end

endmodule
